rob_multi_issue: RTL and testbench

ROB_MULTI_ISSUE -- requirements
Module: rob_multi_issue

---
 rtl/rob_pkg.sv | 32 +++
 rtl/rob_retire_select.sv | 21 ++
 rtl/rob_multi_issue.sv | 164 ++++++++++++++++
 tb/tb_rob_multi_issue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared defaults, tag-width helper and ROB entry layout.
package rob_pkg;

    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned ROB_DISP_W = 2;
    localparam int unsigned ROB_CMP_W  = 4;
    localparam int unsigned ROB_RET_W  = 2;
    localparam int unsigned ROB_PREG_W = 6;
    localparam int unsigned ROB_DATA_W = 32;
    localparam int unsigned ARCH_W     = 5;
    localparam int unsigned PC_W       = 32;

    // Tag width is log2 of the entry count (entry count is a power of two).
    function automatic int unsigned rob_tag_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned ROB_TAG_W = rob_tag_w(ROB_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic                  is_store;
        logic [ARCH_W-1:0]     arch_reg;
        logic [ROB_PREG_W-1:0] dest_preg;
        logic [ROB_PREG_W-1:0] old_preg;
        logic [PC_W-1:0]       pc;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// In-order retire eligibility: lane r retires only if lanes 0..r are all eligible.
module rob_retire_select #(
    parameter int unsigned RET_W = 2
) (
    input  logic             flush,
    input  logic [RET_W-1:0] eligible,
    output logic [RET_W-1:0] ret_valid
);

    // Prefix AND over the eligibility vector, squashed entirely by flush.
    always_comb begin
        logic run;
        ret_valid = '0;
        run       = !flush;
        for (int r = 0; r < RET_W; r++) begin
            run          = run & eligible[r];
            ret_valid[r] = run;
        end
    end

endmodule

// File: rtl/rob_multi_issue.sv
// Multi-issue reorder buffer: compacted multi-lane dispatch, multi-port
// completion and strictly in-order multi-lane retirement.
module rob_multi_issue
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = ROB_DEPTH,
    parameter int unsigned DISP_W = ROB_DISP_W,
    parameter int unsigned CMP_W  = ROB_CMP_W,
    parameter int unsigned RET_W  = ROB_RET_W,
    parameter int unsigned PREG_W = ROB_PREG_W,
    parameter int unsigned DATA_W = ROB_DATA_W,
    localparam int unsigned TAG_W = rob_tag_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W-1:0]          disp_has_dest,
    input  logic [DISP_W-1:0]          disp_is_store,
    input  logic [DISP_W*ARCH_W-1:0]   disp_arch_reg,
    input  logic [DISP_W*PREG_W-1:0]   disp_dest_preg,
    input  logic [DISP_W*PREG_W-1:0]   disp_old_preg,
    input  logic [DISP_W*PC_W-1:0]     disp_pc,
    output logic                       disp_ready,
    output logic [DISP_W*TAG_W-1:0]    disp_tag,
    input  logic [CMP_W-1:0]           cmp_valid,
    input  logic [CMP_W*TAG_W-1:0]     cmp_tag,
    input  logic [CMP_W*DATA_W-1:0]    cmp_data,
    output logic [RET_W-1:0]           ret_valid,
    output logic [RET_W-1:0]           ret_wr_en,
    output logic [RET_W-1:0]           ret_is_store,
    output logic [RET_W*ARCH_W-1:0]    ret_arch_reg,
    output logic [RET_W*DATA_W-1:0]    ret_data,
    output logic [RET_W*PREG_W-1:0]    ret_old_preg,
    output logic [RET_W*PREG_W-1:0]    ret_dest_preg,
    output logic [TAG_W:0]             count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CNT_W = TAG_W + 1;

    rob_entry_t       ent_q [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [TAG_W-1:0] lane_tag [DISP_W];
    rob_entry_t       new_ent  [DISP_W];
    logic [CNT_W-1:0] n_valid;
    logic [CNT_W-1:0] n_disp;
    logic [CNT_W-1:0] n_ret;
    logic             disp_fire;
    logic [TAG_W-1:0] ret_idx  [RET_W];
    logic [RET_W-1:0] eligible;

    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Whole-group admission: needs room for every lane, ignoring same-cycle retires.
    assign disp_ready = !flush && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(DISP_W));
    assign disp_fire  = disp_ready && (|disp_valid);
    assign n_disp     = disp_fire ? n_valid : '0;

    // Compacted tag assignment and new-entry construction per dispatch lane.
    always_comb begin
        disp_tag = '0;
        n_valid  = '0;
        lane_tag = '{default: '0};
        new_ent  = '{default: '0};
        for (int i = 0; i < DISP_W; i++) begin
            lane_tag[i]                 = tail_q + TAG_W'(n_valid);
            disp_tag[i*TAG_W +: TAG_W]  = lane_tag[i];
            n_valid                     = n_valid + CNT_W'(disp_valid[i]);
            new_ent[i].valid            = 1'b1;
            new_ent[i].done             = 1'b0;
            new_ent[i].has_dest         = disp_has_dest[i];
            new_ent[i].is_store         = disp_is_store[i];
            new_ent[i].arch_reg         = disp_arch_reg[i*ARCH_W +: ARCH_W];
            new_ent[i].dest_preg        = ROB_PREG_W'(disp_dest_preg[i*PREG_W +: PREG_W]);
            new_ent[i].old_preg         = ROB_PREG_W'(disp_old_preg[i*PREG_W +: PREG_W]);
            new_ent[i].pc               = disp_pc[i*PC_W +: PC_W];
            new_ent[i].data             = '0;
        end
    end

    // Gather valid+done status of the oldest RET_W entries.
    always_comb begin
        eligible = '0;
        ret_idx  = '{default: '0};
        for (int r = 0; r < RET_W; r++) begin
            ret_idx[r]  = head_q + TAG_W'(r);
            eligible[r] = ent_q[ret_idx[r]].valid & ent_q[ret_idx[r]].done;
        end
    end

    rob_retire_select #(
        .RET_W     (RET_W)
    ) u_retire_select (
        .flush     (flush),
        .eligible  (eligible),
        .ret_valid (ret_valid)
    );

    // Retire payload; lanes that do not retire drive zeros.
    always_comb begin
        ret_wr_en     = '0;
        ret_is_store  = '0;
        ret_arch_reg  = '0;
        ret_data      = '0;
        ret_old_preg  = '0;
        ret_dest_preg = '0;
        n_ret         = '0;
        for (int r = 0; r < RET_W; r++) begin
            if (ret_valid[r]) begin
                ret_wr_en[r]                        = ent_q[ret_idx[r]].has_dest;
                ret_is_store[r]                     = ent_q[ret_idx[r]].is_store;
                ret_arch_reg[r*ARCH_W +: ARCH_W]    = ent_q[ret_idx[r]].arch_reg;
                ret_data[r*DATA_W +: DATA_W]        = DATA_W'(ent_q[ret_idx[r]].data);
                ret_old_preg[r*PREG_W +: PREG_W]    = PREG_W'(ent_q[ret_idx[r]].old_preg);
                ret_dest_preg[r*PREG_W +: PREG_W]   = PREG_W'(ent_q[ret_idx[r]].dest_preg);
            end
            n_ret = n_ret + CNT_W'(ret_valid[r]);
        end
    end

    // Entry array and pointers; later writes (retire, then dispatch) take priority.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int k = 0; k < CMP_W; k++) begin
                if (cmp_valid[k] && ent_q[cmp_tag[k*TAG_W +: TAG_W]].valid) begin
                    ent_q[cmp_tag[k*TAG_W +: TAG_W]].done <= 1'b1;
                    ent_q[cmp_tag[k*TAG_W +: TAG_W]].data <=
                        ROB_DATA_W'(cmp_data[k*DATA_W +: DATA_W]);
                end
            end
            for (int r = 0; r < RET_W; r++) begin
                if (ret_valid[r]) begin
                    ent_q[ret_idx[r]].valid <= 1'b0;
                    ent_q[ret_idx[r]].done  <= 1'b0;
                end
            end
            if (disp_fire) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid[i]) begin
                        ent_q[lane_tag[i]] <= new_ent[i];
                    end
                end
            end
            head_q  <= head_q + TAG_W'(n_ret);
            tail_q  <= tail_q + TAG_W'(n_disp);
            count_q <= count_q + n_disp - n_ret;
        end
    end

endmodule

// File: tb/tb_rob_multi_issue.sv
// Directed self-checking bench for rob_multi_issue with default parameters.
module tb_rob_multi_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [1:0]  disp_valid, disp_has_dest, disp_is_store;
    logic [9:0]  disp_arch_reg;
    logic [11:0] disp_dest_preg, disp_old_preg;
    logic [63:0] disp_pc;
    logic        disp_ready;
    logic [7:0]  disp_tag;
    logic [3:0]  cmp_valid;
    logic [15:0] cmp_tag;
    logic [127:0] cmp_data;
    logic [1:0]  ret_valid, ret_wr_en, ret_is_store;
    logic [9:0]  ret_arch_reg;
    logic [63:0] ret_data;
    logic [11:0] ret_old_preg, ret_dest_preg;
    logic [4:0]  count;
    logic        full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob_multi_issue dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .disp_valid(disp_valid), .disp_has_dest(disp_has_dest),
        .disp_is_store(disp_is_store), .disp_arch_reg(disp_arch_reg),
        .disp_dest_preg(disp_dest_preg), .disp_old_preg(disp_old_preg),
        .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
        .ret_valid(ret_valid), .ret_wr_en(ret_wr_en), .ret_is_store(ret_is_store),
        .ret_arch_reg(ret_arch_reg), .ret_data(ret_data),
        .ret_old_preg(ret_old_preg), .ret_dest_preg(ret_dest_preg),
        .count(count), .full(full), .empty(empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0; disp_has_dest = '0; disp_is_store = '0;
        disp_arch_reg = '0; disp_dest_preg = '0; disp_old_preg = '0; disp_pc = '0;
        cmp_valid = '0; cmp_tag = '0; cmp_data = '0;
    endtask

    task automatic drive_lane(input int i, input logic hd, input logic st,
                              input logic [4:0] arch, input logic [5:0] dst,
                              input logic [5:0] old);
        disp_valid[i]           = 1'b1;
        disp_has_dest[i]        = hd;
        disp_is_store[i]        = st;
        disp_arch_reg[i*5 +: 5] = arch;
        disp_dest_preg[i*6 +: 6] = dst;
        disp_old_preg[i*6 +: 6]  = old;
        disp_pc[i*32 +: 32]     = 32'h1000 + 32'(arch) * 4;
    endtask

    task automatic drive_cmp(input int k, input logic [3:0] tag, input logic [31:0] d);
        cmp_valid[k]          = 1'b1;
        cmp_tag[k*4 +: 4]     = tag;
        cmp_data[k*32 +: 32]  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rstn = 1'b0; flush = 1'b0; idle();
        repeat (2) tick();

        // Reset values while held in reset, with both lanes requesting
        drive_lane(0, 1, 0, 5'd1, 6'd1, 6'd1);
        drive_lane(1, 1, 0, 5'd2, 6'd2, 6'd2);
        #1;
        check_eq("rst_ready", disp_ready, 1);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_ret_valid", ret_valid, 0);
        check_eq("rst_ret_data", ret_data, 0);
        check_eq("rst_tag", disp_tag, 8'h10);
        idle(); rstn = 1'b1;
        tick();

        // Fill: 8 groups of 2, tag t carries arch=t, dest=t+16, old=t
        for (int g = 0; g < 8; g++) begin
            idle();
            drive_lane(0, 1, 0, 5'(2*g),   6'(2*g + 16),   6'(2*g));
            drive_lane(1, 1, 0, 5'(2*g+1), 6'(2*g + 17),   6'(2*g+1));
            #1;
            check_eq("fill_tag", disp_tag, {4'(2*g+1), 4'(2*g)});
            check_eq("fill_ready", disp_ready, 1);
            tick();
        end
        idle(); #1;
        check_eq("full_count", count, 16);
        check_eq("full_flag", full, 1);
        check_eq("full_ready", disp_ready, 0);
        drive_lane(0, 1, 0, 5'd31, 6'd63, 6'd63);
        drive_lane(1, 1, 0, 5'd31, 6'd63, 6'd63);
        tick(); idle(); #1;
        check_eq("held_count", count, 16);
        check_eq("held_tag", disp_tag, 8'h00);

        // Out-of-order completion: tag1 first holds retirement
        drive_cmp(0, 4'd1, 32'hAA);
        tick(); idle(); #1;
        check_eq("ooo_no_ret", ret_valid, 0);
        drive_cmp(0, 4'd0, 32'h55);
        tick(); idle();
        drive_lane(0, 1, 0, 5'd30, 6'd50, 6'd0);
        drive_lane(1, 1, 0, 5'd30, 6'd51, 6'd0);
        #1;
        check_eq("ooo_ret_valid", ret_valid, 2'b11);
        check_eq("ooo_ret_data", ret_data, 64'h000000AA_00000055);
        check_eq("ooo_dest_preg", ret_dest_preg, 12'h450);
        check_eq("ooo_arch_reg", ret_arch_reg, 10'h020);
        check_eq("ooo_old_preg", ret_old_preg, 12'h040);
        check_eq("ooo_wr_en", ret_wr_en, 2'b11);
        check_eq("full_ret_ready", disp_ready, 0);
        tick(); idle(); #1;
        check_eq("full_ret_count", count, 14);
        check_eq("full_ret_nret", ret_valid, 0);

        // Dispatch 2 + retire 2 with room: count unchanged
        drive_cmp(0, 4'd2, 32'h22);
        drive_cmp(1, 4'd3, 32'h33);
        tick(); idle();
        drive_lane(0, 1, 0, 5'd20, 6'd40, 6'd0);
        drive_lane(1, 1, 0, 5'd21, 6'd41, 6'd0);
        #1;
        check_eq("mix_ret_valid", ret_valid, 2'b11);
        check_eq("mix_ready", disp_ready, 1);
        check_eq("mix_tag", disp_tag, 8'h10);
        check_eq("mix_ret_data", ret_data, 64'h00000033_00000022);
        tick(); idle(); #1;
        check_eq("mix_count", count, 14);
        check_eq("mix_idle_tag", disp_tag, 8'h22);

        // Same-tag completion collision: highest port wins
        drive_cmp(0, 4'd4, 32'h11);
        drive_cmp(3, 4'd4, 32'h44);
        tick(); idle(); #1;
        check_eq("coll_ret_valid", ret_valid, 2'b01);
        check_eq("coll_ret_data", ret_data, 64'h00000000_00000044);
        check_eq("coll_dest_preg", ret_dest_preg, 12'h014);
        tick(); #1;
        check_eq("coll_count", count, 13);

        // Move head/tail to 15: 15 single-entry-equivalent dispatches, then drain
        rstn = 1'b0; tick(); rstn = 1'b1;
        for (int g = 0; g < 7; g++) begin
            idle();
            drive_lane(0, 1, 0, 5'(2*g),   6'(2*g),   6'd0);
            drive_lane(1, 1, 0, 5'(2*g+1), 6'(2*g+1), 6'd0);
            tick();
        end
        idle();
        drive_lane(1, 1, 0, 5'd14, 6'd14, 6'd0);
        #1;
        check_eq("compact_tag", disp_tag, 8'hEE);
        tick(); idle();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (4*c + k < 15) drive_cmp(k, 4'(4*c + k), 32'h100 + 32'(4*c + k));
            end
            tick(); idle();
        end
        guard = 0;
        while (!empty && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("drain_empty", empty, 1);

        // Wrap: store on lane0 gets tag 15, lane1 gets tag 0
        drive_lane(0, 0, 1, 5'd3, 6'd5, 6'd6);
        drive_lane(1, 1, 0, 5'd7, 6'd9, 6'd8);
        #1;
        check_eq("wrap_tag", disp_tag, 8'h0F);
        tick(); idle();
        drive_cmp(0, 4'd15, 32'hC0DE);
        drive_cmp(1, 4'd0, 32'hBEEF);
        tick(); idle(); #1;
        check_eq("wrap_ret_valid", ret_valid, 2'b11);
        check_eq("store_is_store", ret_is_store, 2'b01);
        check_eq("store_wr_en", ret_wr_en, 2'b10);
        check_eq("wrap_ret_data", ret_data, 64'h0000BEEF_0000C0DE);
        tick(); #1;
        check_eq("wrap_empty", empty, 1);
        check_eq("wrap_tail", disp_tag, 8'h11);

        // Flush with 5 entries (tags 1..5), 3 done, concurrent dispatch+completion
        drive_lane(0, 1, 0, 5'd1, 6'd1, 6'd0); drive_lane(1, 1, 0, 5'd2, 6'd2, 6'd0);
        tick(); idle();
        drive_lane(0, 1, 0, 5'd3, 6'd3, 6'd0); drive_lane(1, 1, 0, 5'd4, 6'd4, 6'd0);
        tick(); idle();
        drive_lane(0, 1, 0, 5'd5, 6'd5, 6'd0);
        tick(); idle(); #1;
        check_eq("pre_flush_count", count, 5);
        drive_cmp(0, 4'd2, 32'h2); drive_cmp(1, 4'd3, 32'h3); drive_cmp(2, 4'd4, 32'h4);
        tick(); idle(); #1;
        check_eq("pre_flush_nret", ret_valid, 0);
        flush = 1'b1;
        drive_lane(0, 1, 0, 5'd9, 6'd9, 6'd0); drive_lane(1, 1, 0, 5'd9, 6'd9, 6'd0);
        drive_cmp(0, 4'd1, 32'h1);
        #1;
        check_eq("flush_ready", disp_ready, 0);
        check_eq("flush_ret_valid", ret_valid, 0);
        tick(); flush = 1'b0; idle(); #1;
        check_eq("flush_count", count, 0);
        check_eq("flush_empty", empty, 1);
        check_eq("flush_ret", ret_valid, 0);
        check_eq("flush_tail", disp_tag, 8'h00);
        tick(); #1;
        check_eq("flush_still_empty", count, 0);

        // Reset mid-run overrides dispatch and completion
        drive_lane(0, 1, 0, 5'd1, 6'd1, 6'd0); drive_lane(1, 0, 1, 5'd2, 6'd2, 6'd0);
        tick(); idle();
        drive_cmp(0, 4'd0, 32'h99);
        tick(); idle(); #1;
        check_eq("prerst_ret", ret_valid, 2'b01);
        rstn = 1'b0;
        drive_lane(0, 1, 0, 5'd1, 6'd1, 6'd0); drive_lane(1, 1, 0, 5'd2, 6'd2, 6'd0);
        drive_cmp(1, 4'd1, 32'h77);
        tick(); idle(); #1;
        check_eq("mrst_count", count, 0);
        check_eq("mrst_empty", empty, 1);
        check_eq("mrst_full", full, 0);
        check_eq("mrst_ready", disp_ready, 1);
        check_eq("mrst_ret_valid", ret_valid, 0);
        check_eq("mrst_ret_fields", {ret_wr_en, ret_is_store, ret_old_preg, ret_dest_preg}, 0);
        drive_lane(0, 1, 0, 5'd1, 6'd1, 6'd0); drive_lane(1, 1, 0, 5'd2, 6'd2, 6'd0);
        #1;
        check_eq("mrst_tag", disp_tag, 8'h10);
        idle(); rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
